// File: rtl/id_stage_control_if.sv
// rtl/id_stage_control_if.sv - fetch/EX handshake and control-bundle bus of the decode stage
// Purpose: groups every non-clock/reset signal of id_stage_control.
// Ports (slave = decode stage view):
//   in : if_valid, instruction[31:0], flush, ex_ready, ex_rd[4:0], ex_mem_read
//   out: id_ready, ex_valid, ALU_sel[4:0], immediate_sel[2:0], branch_sel[3:0],
//        mem_write[2:0], mem_read[3:0], reg_write_sel[1:0], reg_write_EN,
//        operand1_sel, operand2_sel, illegal_instr, rs1[4:0], rs2[4:0], rd[4:0]
interface id_stage_control_if;
    logic        if_valid;
    logic [31:0] instruction;
    logic        id_ready;
    logic        flush;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_valid;
    logic [4:0]  ALU_sel;
    logic [2:0]  immediate_sel;
    logic [3:0]  branch_sel;
    logic [2:0]  mem_write;
    logic [3:0]  mem_read;
    logic [1:0]  reg_write_sel;
    logic        reg_write_EN;
    logic        operand1_sel;
    logic        operand2_sel;
    logic        illegal_instr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;

    modport master (
        output if_valid, instruction, flush, ex_ready, ex_rd, ex_mem_read,
        input  id_ready, ex_valid, ALU_sel, immediate_sel, branch_sel, mem_write,
               mem_read, reg_write_sel, reg_write_EN, operand1_sel, operand2_sel,
               illegal_instr, rs1, rs2, rd
    );

    modport slave (
        input  if_valid, instruction, flush, ex_ready, ex_rd, ex_mem_read,
        output id_ready, ex_valid, ALU_sel, immediate_sel, branch_sel, mem_write,
               mem_read, reg_write_sel, reg_write_EN, operand1_sel, operand2_sel,
               illegal_instr, rs1, rs2, rd
    );
endinterface

// File: rtl/id_stage_control.sv
// rtl/id_stage_control.sv - RV32IM decode stage with ID/EX register, load-use and M-op stalls
// Purpose: decodes the IF/ID instruction into the control bundle, registers it into
//   the ID/EX boundary, inserts a bubble on load-use hazards, and holds the front end
//   while a multi-cycle M-extension op occupies EX.
// Optional feature macro: RV32M_EN (M-extension decode and MSTALL sequencing; when
//   undefined, funct7=0000001 on OP decodes as illegal and MUL/DIV_CYCLES are unused).
// Ports:
//   CLK   - clock, all state on rising edge
//   RESET - synchronous, active-high
//   bus   - id_stage_control_if.slave (fetch handshake, EX handshake, hazard inputs,
//           registered control bundle)
module id_stage_control #(
    parameter int MUL_CYCLES = 1,
    parameter int DIV_CYCLES = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    id_stage_control_if.slave bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] IMM_U = 3'b000;
    localparam logic [2:0] IMM_J = 3'b001;
    localparam logic [2:0] IMM_I = 3'b010;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_S = 3'b100;

    localparam logic [1:0] WB_PC  = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_ALU = 2'b10;

    // The occupancy counter is 4 bits wide.
    if (MUL_CYCLES < 1 || MUL_CYCLES > 15 || DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_cycles
        $error("id_stage_control: MUL_CYCLES and DIV_CYCLES must be in 1..15");
    end

    typedef struct packed {
        logic       valid;
        logic [4:0] alu_sel;
        logic [2:0] imm_sel;
        logic [3:0] br_sel;
        logic [2:0] mem_wr;
        logic [3:0] mem_rd;
        logic [1:0] wb_sel;
        logic       wb_en;
        logic       op1_sel;
        logic       op2_sel;
        logic       illegal;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } bundle_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = bus.instruction[6:0];
    assign funct3 = bus.instruction[14:12];
    assign funct7 = bus.instruction[31:25];

    bundle_t dec;
    bundle_t q;
    logic    use_rs1;
    logic    use_rs2;
    logic    dec_m;

    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        dec.rs1   = bus.instruction[19:15];
        dec.rs2   = bus.instruction[24:20];
        dec.rd    = bus.instruction[11:7];
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        dec_m     = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec.alu_sel = 5'b11000;
                dec.imm_sel = IMM_U;
                dec.op2_sel = 1'b1;
                dec.wb_en   = 1'b1;
                dec.wb_sel  = WB_ALU;
            end
            OPC_AUIPC: begin
                dec.imm_sel = IMM_U;
                dec.op1_sel = 1'b1;
                dec.op2_sel = 1'b1;
                dec.wb_en   = 1'b1;
                dec.wb_sel  = WB_ALU;
            end
            OPC_JAL: begin
                dec.imm_sel = IMM_J;
                dec.op1_sel = 1'b1;
                dec.op2_sel = 1'b1;
                dec.br_sel  = 4'b1010;
                dec.wb_en   = 1'b1;
                dec.wb_sel  = WB_PC;
            end
            OPC_JALR: begin
                use_rs1     = 1'b1;
                dec.alu_sel = 5'b10000;
                dec.imm_sel = IMM_I;
                dec.op2_sel = 1'b1;
                dec.br_sel  = 4'b1010;
                dec.wb_en   = 1'b1;
                dec.wb_sel  = WB_PC;
            end
            OPC_BRANCH: begin
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                dec.imm_sel = IMM_B;
                dec.op1_sel = 1'b1;
                dec.op2_sel = 1'b1;
                dec.br_sel  = {1'b1, funct3};
            end
            OPC_LOAD: begin
                use_rs1     = 1'b1;
                dec.imm_sel = IMM_I;
                dec.op2_sel = 1'b1;
                dec.mem_rd  = {1'b1, funct3};
                dec.wb_en   = 1'b1;
                dec.wb_sel  = WB_MEM;
            end
            OPC_STORE: begin
                use_rs1     = 1'b1;
                use_rs2     = 1'b1;
                dec.imm_sel = IMM_S;
                dec.op2_sel = 1'b1;
                dec.mem_wr  = {1'b1, funct3[1:0]};
            end
            OPC_OPIMM: begin
                use_rs1     = 1'b1;
                dec.imm_sel = IMM_I;
                dec.op2_sel = 1'b1;
                // Only SRAI carries an arithmetic flag; for ADDI etc. bit 30 is immediate data.
                dec.alu_sel = {(funct3 == 3'b101) & funct7[5], 1'b0, funct3};
                dec.wb_en   = 1'b1;
                dec.wb_sel  = WB_ALU;
            end
            OPC_OP: begin
                // Hazard tracking is by opcode, so an illegal OP still compares both sources.
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    dec.alu_sel = {funct7[5], 1'b0, funct3};
                    dec.wb_en   = 1'b1;
                    dec.wb_sel  = WB_ALU;
                end
`ifdef RV32M_EN
                else if (funct7 == 7'b0000001) begin
                    dec.alu_sel = {2'b01, funct3};
                    dec.wb_en   = 1'b1;
                    dec.wb_sel  = WB_ALU;
                    dec_m       = 1'b1;
                end
`endif
                else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    logic hazard;
    logic upd;
    logic id_ready;
    logic take;

    assign hazard = q.valid & bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                    ((use_rs1 & (bus.ex_rd == dec.rs1)) | (use_rs2 & (bus.ex_rd == dec.rs2)));
    assign upd    = ~q.valid | bus.ex_ready;
    assign take   = bus.if_valid & id_ready;

`ifdef RV32M_EN
    typedef enum logic {ST_RUN, ST_MSTALL} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] dec_cycles;

    // funct3[2] separates the divide group from the multiply group.
    assign dec_cycles = funct3[2] ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
    assign id_ready   = (state == ST_RUN) & ~hazard & upd & ~bus.flush;

    always_ff @(posedge CLK) begin
        if (RESET || bus.flush) begin
            q     <= '0;
            state <= ST_RUN;
            cnt   <= 4'd0;
        end else if (upd) begin
            if (take) begin
                q <= dec;
                if (dec_m && dec_cycles > 4'd1) begin
                    state <= ST_MSTALL;
                    cnt   <= dec_cycles - 4'd1;
                end
            end else begin
                q <= '0;
                if (state == ST_MSTALL) begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ST_RUN;
                    end
                end
            end
        end
    end
`else
    assign id_ready = ~hazard & upd & ~bus.flush;

    always_ff @(posedge CLK) begin
        if (RESET || bus.flush) begin
            q <= '0;
        end else if (upd) begin
            q <= take ? dec : '0;
        end
    end
`endif

    assign bus.id_ready      = id_ready;
    assign bus.ex_valid      = q.valid;
    assign bus.ALU_sel       = q.alu_sel;
    assign bus.immediate_sel = q.imm_sel;
    assign bus.branch_sel    = q.br_sel;
    assign bus.mem_write     = q.mem_wr;
    assign bus.mem_read      = q.mem_rd;
    assign bus.reg_write_sel = q.wb_sel;
    assign bus.reg_write_EN  = q.wb_en;
    assign bus.operand1_sel  = q.op1_sel;
    assign bus.operand2_sel  = q.op2_sel;
    assign bus.illegal_instr = q.illegal;
    assign bus.rs1           = q.rs1;
    assign bus.rs2           = q.rs2;
    assign bus.rd            = q.rd;
endmodule

// File: tb/tb_id_stage_control.sv
// tb/tb_id_stage_control.sv - self-checking bench for id_stage_control
module tb_id_stage_control;
    localparam int MUL_N = 1;
    localparam int DIV_N = 8;
`ifdef RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    id_stage_control_if bus ();

    id_stage_control #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Expected registered bundle, layout:
    // {valid, alu[5], imm[3], br[4], mw[3], mr[4], ws[2], we, op1, op2, ill, rs1, rs2, rd}
    logic [40:0] m_bundle;
    int          stall_left;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [40:0] obs_bundle();
        return {bus.ex_valid, bus.ALU_sel, bus.immediate_sel, bus.branch_sel, bus.mem_write,
                bus.mem_read, bus.reg_write_sel, bus.reg_write_EN, bus.operand1_sel,
                bus.operand2_sel, bus.illegal_instr, bus.rs1, bus.rs2, bus.rd};
    endfunction

    function automatic logic [40:0] ref_bundle(input logic [31:0] ins);
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        logic [4:0] alu = '0;
        logic [2:0] imm = '0;
        logic [3:0] br = '0;
        logic [2:0] mw = '0;
        logic [3:0] mr = '0;
        logic [1:0] ws = '0;
        logic we = 0, o1 = 0, o2 = 0, ill = 0;
        case (ins[6:0])
            7'h37: begin alu = 5'b11000; o2 = 1; we = 1; ws = 2'b10; end
            7'h17: begin o1 = 1; o2 = 1; we = 1; ws = 2'b10; end
            7'h6F: begin imm = 3'd1; o1 = 1; o2 = 1; br = 4'b1010; we = 1; end
            7'h67: begin imm = 3'd2; alu = 5'b10000; o2 = 1; br = 4'b1010; we = 1; end
            7'h63: begin imm = 3'd3; o1 = 1; o2 = 1; br = {1'b1, f3}; end
            7'h03: begin imm = 3'd2; o2 = 1; mr = {1'b1, f3}; we = 1; ws = 2'b01; end
            7'h23: begin imm = 3'd4; o2 = 1; mw = {1'b1, f3[1:0]}; end
            7'h13: begin
                imm = 3'd2; o2 = 1; we = 1; ws = 2'b10;
                alu = {(f3 == 3'd5) && f7[5], 1'b0, f3};
            end
            7'h33: begin
                if (f7 == 7'h00) alu = {2'b00, f3};
                else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) alu = {2'b10, f3};
                else if (M_EN && f7 == 7'h01) alu = {2'b01, f3};
                else ill = 1;
                if (!ill) begin we = 1; ws = 2'b10; end
            end
            default: ill = 1;
        endcase
        return {1'b1, alu, imm, br, mw, mr, ws, we, o1, o2, ill, ins[19:15], ins[24:20], ins[11:7]};
    endfunction

    function automatic logic ref_uses_rs1(input logic [31:0] ins);
        return ins[6:0] inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    endfunction

    function automatic logic ref_uses_rs2(input logic [31:0] ins);
        return ins[6:0] inside {7'h33, 7'h63, 7'h23};
    endfunction

    function automatic int ref_stall(input logic [31:0] ins);
        if (M_EN && ins[6:0] == 7'h33 && ins[31:25] == 7'h01)
            return (ins[14] ? DIV_N : MUL_N) - 1;
        return 0;
    endfunction

    function automatic logic ref_hazard(input logic [31:0] ins);
        logic [4:0] er = bus.ex_rd;
        if (!m_bundle[40] || !bus.ex_mem_read || er == 5'd0) return 1'b0;
        return (ref_uses_rs1(ins) && ins[19:15] == er) || (ref_uses_rs2(ins) && ins[24:20] == er);
    endfunction

    // One clock: check at the falling edge, advance the model, then drive the EX-side
    // hazard inputs the way the following stage would (from the model's bundle).
    task automatic step();
        logic upd, exp_rdy;
        @(negedge CLK);
        upd     = !m_bundle[40] || bus.ex_ready;
        exp_rdy = (stall_left == 0) && !ref_hazard(bus.instruction) && upd && !bus.flush;
        check("id_ready", bus.id_ready, exp_rdy);
        check("bundle", obs_bundle(), m_bundle);
        if (RESET || bus.flush) begin
            m_bundle   = '0;
            stall_left = 0;
        end else if (upd) begin
            if (bus.if_valid && exp_rdy) begin
                m_bundle   = ref_bundle(bus.instruction);
                stall_left = ref_stall(bus.instruction);
            end else begin
                m_bundle = '0;
                if (stall_left > 0) stall_left--;
            end
        end
        @(posedge CLK);
        #1;
        cyc++;
        bus.ex_rd       = m_bundle[4:0];
        bus.ex_mem_read = m_bundle[24];
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] r = $urandom;
        logic [4:0] a = 5'($urandom_range(0, 3));
        logic [4:0] b = 5'($urandom_range(0, 3));
        logic [4:0] d = 5'($urandom_range(0, 3));
        logic [2:0] f = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 12))
            0:  return {r[31:12], d, 7'h37};
            1:  return {r[31:12], d, 7'h17};
            2:  return {r[31:12], d, 7'h6F};
            3:  return {r[31:20], a, 3'b000, d, 7'h67};
            4:  return {r[31:25], b, a, f, r[11:7], 7'h63};
            5:  return {r[31:20], a, f, d, 7'h03};
            6:  return {r[31:25], b, a, f, r[11:7], 7'h23};
            7:  return {r[31:20], a, f, d, 7'h13};
            8:  return {7'h00, b, a, f, d, 7'h33};
            9:  return {7'h20, b, a, (r[0] ? 3'b000 : 3'b101), d, 7'h33};
            10: return {7'h01, b, a, f, d, 7'h33};
            11: return {r[31:7], 7'h7F};
            default: return r;
        endcase
    endfunction

    initial begin
        RESET           = 1'b1;
        bus.if_valid    = 1'b0;
        bus.instruction = '0;
        bus.flush       = 1'b0;
        bus.ex_ready    = 1'b1;
        bus.ex_rd       = '0;
        bus.ex_mem_read = 1'b0;
        m_bundle        = '0;
        stall_left      = 0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        #1;
        check("rst_ex_valid", bus.ex_valid, 1'b0);
        check("rst_bundle", obs_bundle(), 41'd0);
        check("rst_id_ready", bus.id_ready, 1'b1);

        // ADDI x1,x2,5
        bus.if_valid    = 1'b1;
        bus.instruction = 32'h00510093;
        step();
        check("addi_valid", bus.ex_valid, 1'b1);
        check("addi_alu", bus.ALU_sel, 5'b00000);
        check("addi_imm", bus.immediate_sel, 3'b010);
        check("addi_op2", bus.operand2_sel, 1'b1);
        check("addi_wsel", bus.reg_write_sel, 2'b10);
        check("addi_rd", bus.rd, 5'd1);

        // Load-use: LW x3,0(x1) then ADD x4,x3,x1
        bus.instruction = 32'h0000A183;
        step();
        bus.instruction = 32'h00118233;
        #1;
        check("lu_ex_rd", bus.ex_rd, 5'd3);
        check("lu_stall_ready", bus.id_ready, 1'b0);
        step();
        #1;
        check("lu_bubble", bus.ex_valid, 1'b0);
        check("lu_ready_again", bus.id_ready, 1'b1);
        step();
        check("lu_add_valid", bus.ex_valid, 1'b1);
        check("lu_add_rs1", bus.rs1, 5'd3);

        // DIV x5,x6,x7
        bus.instruction = 32'h027342B3;
        step();
`ifdef RV32M_EN
        check("div_alu", bus.ALU_sel, 5'b01100);
        bus.instruction = 32'h00510093;
        for (int k = 0; k < 7; k++) begin
            #1;
            check("div_stall_ready", bus.id_ready, 1'b0);
            step();
        end
        #1;
        check("div_ready_cycle8", bus.id_ready, 1'b1);
        step();
        check("div_next_accepted", bus.ex_valid, 1'b1);
        check("div_next_rd", bus.rd, 5'd1);

        // Flush during MSTALL at cnt=4
        bus.instruction = 32'h027342B3;
        step();
        bus.instruction = 32'h00510093;
        repeat (3) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        #1;
        check("flush_bubble", bus.ex_valid, 1'b0);
        check("flush_ready", bus.id_ready, 1'b1);
        step();
`else
        check("div_illegal", bus.illegal_instr, 1'b1);
        check("div_no_wb", bus.reg_write_EN, 1'b0);
        check("div_valid", bus.ex_valid, 1'b1);
`endif

        // Backpressure with JAL registered
        bus.instruction = 32'h0080006F;
        step();
        bus.ex_ready    = 1'b0;
        bus.instruction = 32'h00510093;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_branch_sel", bus.branch_sel, 4'b1010);
            check("bp_imm_sel", bus.immediate_sel, 3'b001);
            check("bp_wsel", bus.reg_write_sel, 2'b00);
            check("bp_id_ready", bus.id_ready, 1'b0);
            step();
        end
        bus.ex_ready = 1'b1;
        step();

        // Unknown opcode 0x7F
        bus.instruction = 32'h0000007F;
        step();
        check("ill_flag", bus.illegal_instr, 1'b1);
        check("ill_valid", bus.ex_valid, 1'b1);
        check("ill_we", bus.reg_write_EN, 1'b0);
        check("ill_mw", bus.mem_write, 3'b000);
        check("ill_mr", bus.mem_read, 4'b0000);
        check("ill_br", bus.branch_sel, 4'b0000);

        // Reset with a valid bundle registered
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("mid_reset_bundle", obs_bundle(), 41'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            bus.if_valid    = ($urandom_range(0, 3) != 0);
            bus.instruction = gen_instr();
            bus.ex_ready    = ($urandom_range(0, 3) != 0);
            bus.flush       = ($urandom_range(0, 24) == 0);
            RESET           = ($urandom_range(0, 99) == 0);
            step();
        end
        RESET     = 1'b0;
        bus.flush = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
